tick_scheduler: RTL

Shares one free-running prescaler among several independently programmable timing channels. It replaces ad-hoc per-consumer divider instances in the clock/timer datapath. The prescaler turns the 50 kHz system clock into a base tick (1 kHz by default). Each channel counts base ticks and emits single-cycle enable pulses, periodic or one-shot, under control of a valid/ready command port.

---
 rtl/tick_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// Shared-prescaler tick scheduler: one free-running base-tick divider feeding
// CH_COUNT independently programmable periodic / one-shot enable channels.
module tick_scheduler #(
  parameter int PRESCALE = 50,
  parameter int CH_COUNT = 4,
  parameter int CH_W     = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [1:0]          cfg_op,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic                cfg_oneshot,
  output logic                cfg_err,
  output logic                base_tick,
  output logic [CH_COUNT-1:0] tick_out,
  output logic [CH_COUNT-1:0] busy
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_START   = 2'b01;
  localparam logic [1:0] OP_STOP    = 2'b10;
  localparam logic [1:0] OP_RESTART = 2'b11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  logic [PRE_W-1:0] pre_cnt;
  ch_state_t        state_q [CH_COUNT];
  ch_state_t        state_d [CH_COUNT];
  logic [CNT_W-1:0] cnt_q   [CH_COUNT];
  logic [CNT_W-1:0] cnt_d   [CH_COUNT];
  logic [CNT_W-1:0] per_q   [CH_COUNT];
  logic [CNT_W-1:0] per_d   [CH_COUNT];
  logic             mode_q  [CH_COUNT];
  logic             mode_d  [CH_COUNT];
  logic [CH_COUNT-1:0] tick_d;
  logic             err_d;
  logic             accept;
  logic             ch_ok;

  // Handshake: a command transfers on a rising edge with cfg_valid & cfg_ready
  // both high; cfg_ready then drops for one cycle, and the requester must hold
  // its fields stable while cfg_valid is high and cfg_ready is low.
  assign accept = cfg_valid & cfg_ready;
  assign ch_ok  = int'(cfg_ch) < CH_COUNT;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      tick_out  <= '0;
      for (int i = 0; i < CH_COUNT; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        per_q[i]   <= '0;
        mode_q[i]  <= 1'b0;
      end
    end else begin
      pre_cnt   <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PRE_W'(1);
      base_tick <= (pre_cnt == PRE_MAX);
      cfg_ready <= ~accept;
      cfg_err   <= err_d;
      tick_out  <= tick_d;
      for (int i = 0; i < CH_COUNT; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        per_q[i]   <= per_d[i];
        mode_q[i]  <= mode_d[i];
      end
    end
  end

  always_comb begin
    err_d  = 1'b0;
    tick_d = '0;
    for (int i = 0; i < CH_COUNT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      per_d[i]   = per_q[i];
      mode_d[i]  = mode_q[i];
    end
    if (accept && cfg_op != OP_NOP && !ch_ok) err_d = 1'b1;
    for (int i = 0; i < CH_COUNT; i++) begin
      // A command aimed at this channel takes priority over a coincident base tick.
      if (accept && cfg_op != OP_NOP && int'(cfg_ch) == i) begin
        case (cfg_op)
          OP_START: begin
            if (cfg_period == '0) begin
              err_d = 1'b1;
            end else begin
              per_d[i]   = cfg_period;
              mode_d[i]  = cfg_oneshot;
              cnt_d[i]   = cfg_period;
              state_d[i] = RUN;
            end
          end
          OP_STOP: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
          OP_RESTART: begin
            if (per_q[i] == '0) begin
              err_d = 1'b1;
            end else begin
              cnt_d[i]   = per_q[i];
              state_d[i] = RUN;
            end
          end
          default: ;
        endcase
      end else if (base_tick && state_q[i] == RUN) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          tick_d[i] = 1'b1;
          if (mode_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = per_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // busy is the per-channel FSM state, visible for observation.
  always_comb begin
    busy = '0;
    for (int i = 0; i < CH_COUNT; i++) busy[i] = (state_q[i] == RUN);
  end

endmodule
